// File: rtl/ng_kbd.sv
// DSKY keyboard front end: input synchronizer, press/release debounce,
// keycode queue and keyboard interrupt strobe generation.
//
// state    | meaning
// IDLE     | no key down, waiting for kd
// PRESS_DB | key seen, counting stable samples of kd and kc
// HELD     | press accepted and queued, waiting for release
// REL_DB   | release seen, counting stable low samples of kd

module ng_kbd #(
    parameter int DB_CYCLES  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STR_WIDTH  = 4
) (
    input  logic        clk2_i,
    input  logic        genrst_i,
    input  logic        key_down_i,
    input  logic [4:0]  key_code_i,
    input  logic        rd_kbd_i,
    output logic        kb_str_o,
    output logic [15:0] kbd_bus_o,
    output logic        kb_rdy_o
);

    localparam int CNT_W  = $clog2(DB_CYCLES) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int STR_CW = $clog2(STR_WIDTH + 1);
    localparam int STR_GAP = 2;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0]  DB_ONE    = CNT_W'(1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [STR_CW-1:0] STR_LOAD  = STR_CW'(STR_WIDTH - 1);
    localparam logic [1:0]        GAP_LOAD  = 2'(STR_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic        kd_s1_q, kd_q;
    logic [4:0]  kc_s1_q, kc_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic [4:0]        cap_q, cap_d;
    logic              push_q, push_d;

    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              ovf_q, ovf_d;
    logic [4:0]        head_q, head_d;
    logic              rdy_q, rdy_d;
    logic              pop, full, wr_en, drop, trig;

    logic              kb_str_q, kb_str_d;
    logic [STR_CW-1:0] str_cnt_q, str_cnt_d;
    logic [1:0]        gap_q, gap_d;
    logic              pend_q, pend_d;
    logic              can_start;

    always_ff @(posedge clk2_i) begin
        if (genrst_i) begin
            kd_s1_q <= 1'b0;
            kd_q    <= 1'b0;
            kc_s1_q <= '0;
            kc_q    <= '0;
        end else begin
            kd_s1_q <= key_down_i;
            kd_q    <= kd_s1_q;
            kc_s1_q <= key_code_i;
            kc_q    <= kc_s1_q;
        end
    end

    always_ff @(posedge clk2_i) begin
        if (genrst_i) begin
            state_q  <= S_IDLE;
            db_cnt_q <= '0;
            cap_q    <= '0;
            push_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            cap_q    <= cap_d;
            push_q   <= push_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        cap_d    = cap_q;
        push_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kd_q) begin
                    state_d  = S_PRESS_DB;
                    db_cnt_d = DB_ONE;
                    cap_d    = kc_q;
                end
            end
            S_PRESS_DB: begin
                if (!kd_q) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (kc_q != cap_q) begin
                    cap_d    = kc_q;
                    db_cnt_d = DB_ONE;
                end else if (db_cnt_q == DB_LAST) begin
                    push_d   = 1'b1;
                    state_d  = S_HELD;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            S_HELD: begin
                if (!kd_q) begin
                    state_d  = S_REL_DB;
                    db_cnt_d = DB_ONE;
                end
            end
            S_REL_DB: begin
                if (kd_q) begin
                    state_d  = S_HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    // The push register holds the accepted code in cap_q; HELD never recaptures.
    always_comb begin
        pop   = rd_kbd_i && (fcnt_q != '0);
        full  = (fcnt_q == FIFO_FULL);
        wr_en = push_q && (!full || pop);
        drop  = push_q && full && !pop;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fcnt_d   = fcnt_q + FCNT_W'(wr_en) - FCNT_W'(pop);

        ovf_d = ovf_q;
        if (rd_kbd_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        // Next head may be the slot written on this very edge.
        if (fcnt_d == '0) begin
            head_d = '0;
        end else if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            head_d = cap_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        rdy_d = (fcnt_d != '0);

        trig = (wr_en && (fcnt_q == '0)) || (pop && (fcnt_d != '0));
    end

    always_ff @(posedge clk2_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    always_ff @(posedge clk2_i) begin
        if (genrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
            rdy_q    <= rdy_d;
        end
    end

    // Strobe: STR_WIDTH high cycles, then at least STR_GAP low cycles before
    // a pending trigger may fire.
    always_comb begin
        kb_str_d  = kb_str_q;
        str_cnt_d = str_cnt_q;
        gap_d     = gap_q;
        pend_d    = pend_q;
        can_start = !kb_str_q && (gap_q == '0);

        if (kb_str_q) begin
            if (str_cnt_q == '0) begin
                kb_str_d = 1'b0;
                gap_d    = GAP_LOAD;
            end else begin
                str_cnt_d = str_cnt_q - STR_CW'(1);
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - 2'd1;
        end

        if (can_start && (trig || pend_q)) begin
            kb_str_d  = 1'b1;
            str_cnt_d = STR_LOAD;
            pend_d    = pend_q && trig;
        end else if (trig) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk2_i) begin
        if (genrst_i) begin
            kb_str_q  <= 1'b0;
            str_cnt_q <= '0;
            gap_q     <= '0;
            pend_q    <= 1'b0;
        end else begin
            kb_str_q  <= kb_str_d;
            str_cnt_q <= str_cnt_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
        end
    end

    assign kb_str_o  = kb_str_q;
    assign kbd_bus_o = {ovf_q, 10'b0, head_q};
    assign kb_rdy_o  = rdy_q;

endmodule

// File: tb/tb_ng_kbd.sv
// Directed bench for ng_kbd: operation table for queue/overflow/interrupt
// behaviour plus hand sequences for latency, bounce, coincidence and reset.

module tb_ng_kbd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kd  = 1'b0;
    logic [4:0]  kc  = '0;
    logic        rd  = 1'b0;
    logic        kb_str;
    logic [15:0] kbd_bus;
    logic        kb_rdy;

    int n_cmp = 0;
    int n_bad = 0;
    int str_rises = 0;
    logic str_prev = 1'b0;

    ng_kbd #(.DB_CYCLES(16), .FIFO_DEPTH(4), .STR_WIDTH(4)) dut (
        .clk2_i     (clk),
        .genrst_i   (rst),
        .key_down_i (kd),
        .key_code_i (kc),
        .rd_kbd_i   (rd),
        .kb_str_o   (kb_str),
        .kbd_bus_o  (kbd_bus),
        .kb_rdy_o   (kb_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         op;        // 0 = press and release, 1 = single read
        logic [4:0] code;
        logic [15:0] exp_bus;
        logic       exp_rdy;
        int         exp_rises;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
        if (kb_str && !str_prev) str_rises++;
        str_prev = kb_str;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        kd  = 1'b0;
        kc  = '0;
        rd  = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    // Key down from the next edge (cycle 0); rd pulses on edge rd_at.
    task automatic press(input logic [4:0] code, input int rd_at);
        kd = 1'b1;
        kc = code;
        for (int c = 0; c < 40; c++) begin
            rd = (c == rd_at);
            tick();
        end
        rd = 1'b0;
        kd = 1'b0;
        kc = '0;
        run(40);
    endtask

    task automatic read_once();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic press_reset(input logic [4:0] code, input int rc);
        logic [40:0] rdy_hist, exp_rdy_hist;
        do_reset();
        kd = 1'b1;
        kc = code;
        run(rc);
        check("pre_reset_str", 64'(kb_str), 64'((rc - 1 >= 19) && (rc - 1 <= 22)));
        check("pre_reset_rdy", 64'(kb_rdy), 64'(rc - 1 >= 19));
        rst = 1'b1;
        tick();
        check("reset_outputs", {47'd0, kbd_bus, kb_rdy}, 64'd0);
        check("reset_str", 64'(kb_str), 64'd0);
        rst = 1'b0;
        str_rises = 0;
        for (int c = 0; c <= 40; c++) begin
            tick();
            rdy_hist[c]     = kb_rdy;
            exp_rdy_hist[c] = (c >= 19);
        end
        check("rereset_rdy_timing", 64'(rdy_hist), 64'(exp_rdy_hist));
        check("rereset_bus", 64'(kbd_bus), {48'd0, 11'd0, code});
        kd = 1'b0;
        run(40);
        check("rereset_single_push", 64'(str_rises), 64'd1);
    endtask

    initial begin
        logic [40:0] str_hist, exp_str, rdy_hist, exp_rdy;
        logic [12:0] pend_hist;
        logic [12:0] exp_pend;

        tbl[0] = '{0, 5'o21, 16'h0011, 1'b1, 1};
        tbl[1] = '{0, 5'o04, 16'h0011, 1'b1, 0};
        tbl[2] = '{0, 5'o37, 16'h0011, 1'b1, 0};
        tbl[3] = '{0, 5'o12, 16'h0011, 1'b1, 0};
        tbl[4] = '{0, 5'o25, 16'h8011, 1'b1, 0};
        tbl[5] = '{1, 5'o00, 16'h0004, 1'b1, 1};
        tbl[6] = '{1, 5'o00, 16'h001f, 1'b1, 1};
        tbl[7] = '{1, 5'o00, 16'h000a, 1'b1, 1};
        tbl[8] = '{1, 5'o00, 16'h0000, 1'b0, 0};
        tbl[9] = '{1, 5'o00, 16'h0000, 1'b0, 0};

        // Reset state
        do_reset();
        check("reset_bus", 64'(kbd_bus), 64'd0);
        check("reset_rdy_str", {62'd0, kb_rdy, kb_str}, 64'd0);

        // Clean press latency, code 21 octal
        str_rises = 0;
        kd = 1'b1;
        kc = 5'o21;
        for (int c = 0; c <= 40; c++) begin
            tick();
            str_hist[c] = kb_str;
            rdy_hist[c] = kb_rdy;
            exp_str[c]  = (c >= 19) && (c <= 22);
            exp_rdy[c]  = (c >= 19);
        end
        check("latency_str", 64'(str_hist), 64'(exp_str));
        check("latency_rdy", 64'(rdy_hist), 64'(exp_rdy));
        check("latency_bus", 64'(kbd_bus), 64'h0011);
        kd = 1'b0;
        run(40);
        check("latency_single_irq", 64'(str_rises), 64'd1);
        read_once();
        check("latency_single_entry", {47'd0, kbd_bus, kb_rdy}, 64'd0);

        // Bouncing key with changing codes, then stable code 04
        do_reset();
        str_rises = 0;
        for (int c = 0; c < 30; c++) begin
            kd = (c % 3 != 2);
            kc = (c % 2 == 0) ? 5'o04 : 5'o13;
            tick();
        end
        check("bounce_no_push", 64'(kb_rdy), 64'd0);
        kd = 1'b1;
        kc = 5'o04;
        run(40);
        kd = 1'b0;
        run(40);
        check("bounce_bus", 64'(kbd_bus), 64'h0004);
        check("bounce_irq_count", 64'(str_rises), 64'd1);
        read_once();
        check("bounce_single_entry", {47'd0, kbd_bus, kb_rdy}, 64'd0);

        // Operation table: fill, overflow, drain, empty read
        do_reset();
        for (int i = 0; i < 10; i++) begin
            str_rises = 0;
            if (tbl[i].op == 0) begin
                press(tbl[i].code, -1);
            end else begin
                read_once();
                run(20);
            end
            check($sformatf("tbl%0d_bus", i), 64'(kbd_bus), 64'(tbl[i].exp_bus));
            check($sformatf("tbl%0d_rdy", i), 64'(kb_rdy), 64'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d_irq", i), 64'(str_rises), 64'(tbl[i].exp_rises));
        end

        // Full queue with read coincident with push, then pending strobe
        do_reset();
        press(5'd1, -1);
        press(5'd2, -1);
        press(5'd3, -1);
        press(5'd4, -1);
        check("full_bus", 64'(kbd_bus), 64'h0001);
        press(5'd5, 19);
        check("coincident_bus", 64'(kbd_bus), 64'h0002);
        exp_pend = 13'b0001111001111;
        for (int c = 0; c < 13; c++) begin
            rd = (c < 2);
            tick();
            pend_hist[c] = kb_str;
        end
        rd = 1'b0;
        check("pending_str", 64'(pend_hist), 64'(exp_pend));
        check("after_two_reads_bus", 64'(kbd_bus), 64'h0004);
        read_once();
        check("tail_bus", 64'(kbd_bus), 64'h0005);
        read_once();
        check("drained", {47'd0, kbd_bus, kb_rdy}, 64'd0);

        // Reset mid-debounce and mid-strobe with the key still held
        press_reset(5'o23, 12);
        press_reset(5'o07, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ng_kbd.md
NG_KBD -- requirements
Module: ng_KBD

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 16, the number of consecutive stable synchronized samples required to accept a press or a release.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, the keycode queue depth; it must be a power of two, at least 2.
REQ-003 SHALL provide parameter STR_WIDTH, default 4, the KB_STR pulse width in CLK2 cycles.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK2  input  1  system clock; all state changes on its rising edge.
REQ-006 GENRST  input  1  synchronous active-high reset.
REQ-007 KEY_DOWN  input  1  raw, asynchronous, bouncing key-pressed level from the DSKY matrix.
REQ-008 KEY_CODE  input  5  raw, asynchronous keycode; meaningful only while KEY_DOWN=1.
REQ-009 RD_KBD  input  1  one-cycle read/acknowledge strobe from the channel read path.
REQ-010 KB_STR  output  1  keyboard interrupt request pulse, wired to the interrupt block's KB_STR input.
REQ-011 KBD_BUS  output  16  {KB_OVF, 10'b0, head keycode[4:0]}; head keycode reads 0 when the queue is empty.
REQ-012 KB_RDY  output  1  queue non-empty.

Function
REQ-013 SHALL pass KEY_DOWN and KEY_CODE through a 2-flop synchronizer; all logic below uses only the synchronized values (kd, kc).
REQ-014 SHALL implement FSM IDLE, PRESS_DB, HELD, REL_DB with a debounce counter of width clog2(DB_CYCLES)+1.
REQ-015 IDLE: kd=1 -> PRESS_DB, counter=1, capture kc.
REQ-016 PRESS_DB: kd=0 -> IDLE; kc differs from the captured code -> recapture, counter=1; otherwise counter+1; when counter reaches DB_CYCLES -> push the captured code, go to HELD.
REQ-017 HELD: kd=0 -> REL_DB, counter=1; no autorepeat, no further push.
REQ-018 REL_DB: kd=1 -> HELD; otherwise counter+1; when counter reaches DB_CYCLES -> IDLE.
REQ-019 Latency: KEY_DOWN stable high with a stable code from cycle 0 -> push at cycle DB_CYCLES+2; KBD_BUS/KB_RDY updated and KB_STR rising at cycle DB_CYCLES+3.
REQ-020 Queue: circular FIFO_DEPTH-entry buffer; pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-021 RD_KBD=1 with the queue non-empty -> pop the head; RD_KBD=1 with the queue empty -> no pop.
REQ-022 Any RD_KBD=1 clears KB_OVF on the same edge; a push in that cycle that sets KB_OVF wins.
REQ-023 Push into a full queue with no pop in that cycle -> code dropped, KB_OVF set (sticky), queue unchanged.
REQ-024 Simultaneous push and pop -> both take effect and count is unchanged; this applies when full and when count=1.
REQ-025 KB_STR pulse, STR_WIDTH cycles, is triggered by a push into an empty queue, or by a pop that leaves the queue non-empty, so each queued code raises exactly one interrupt.
REQ-026 A trigger arriving while KB_STR is high or within 2 cycles after it falls is held pending and pulsed once KB_STR has been low for 2 cycles; at most one trigger is pending.
REQ-027 All outputs are registered.

Reset
REQ-028 GENRST=1 -> FSM=IDLE, counter=0, synchronizers=0, queue empty, pointers=0, KB_OVF=0, pending=0, KB_STR=0, KB_RDY=0, KBD_BUS=16'h0000, on the next CLK2 edge.
REQ-029 Reset mid-debounce or mid-pulse aborts immediately; a key still held after reset is re-debounced from IDLE and pushed once.

Verification
REQ-030 Clean press of code 5'o21 held 40 cycles, DB_CYCLES=16 -> KB_STR high cycles 19-22, KBD_BUS=16'h0011, KB_RDY=1; a single push only.
REQ-031 KEY_DOWN bouncing at 3-cycle period for 30 cycles, then stable on code 5'o04 -> exactly one push of 5'o04, none during the bounce.
REQ-032 Five presses with no reads, FIFO_DEPTH=4 -> queue holds the first 4 codes, KBD_BUS[15]=1; RD_KBD pops the first code, clears KB_OVF, and pulses KB_STR after the 2-cycle gap.
REQ-033 Queue full, RD_KBD coincident with a push -> count stays 4, no overflow, the new code is at the tail.
REQ-034 RD_KBD on an empty queue -> KBD_BUS=16'h0000, no KB_STR, pointers unchanged.
REQ-035 GENRST asserted at cycle 10 of PRESS_DB with the key held -> all outputs zero; push occurs DB_CYCLES+2 cycles after reset deasserts.
